// File: rtl/uart_pkg.sv
// Shared UART definitions used by the transmit framer and the receive-side error checker.
// Holds the parity encodings, the framer state encoding and the frame width.
package uart_pkg;

    localparam logic [1:0] PARITY_ODD  = 2'b01;
    localparam logic [1:0] PARITY_EVEN = 2'b10;
    localparam int         DATA_BITS   = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    // 2'b00 and 2'b11 both mean "no parity bit in the frame".
    function automatic logic parity_enabled(input logic [1:0] parity_type);
        return (parity_type == PARITY_ODD) || (parity_type == PARITY_EVEN);
    endfunction

    function automatic logic parity_bit(input logic [DATA_BITS-1:0] data,
                                        input logic [1:0]           parity_type);
        return (parity_type == PARITY_ODD) ? ~^data : ^data;
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-time down-counter: reloads CLKS_PER_BIT-1 on clear or after reaching zero,
// and flags bit_end during the last clk cycle of every serial bit.
module uart_baud_cnt #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic bit_end
);

    localparam int                CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  ONE   = CNT_W'(1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear || (cnt == '0)) begin
            cnt <= LAST;
        end else begin
            cnt <= cnt - ONE;
        end
    end

    // While held in clear the counter is parked, so no bit boundary is reported.
    assign bit_end = (cnt == '0) && !clear;

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmit framer: start, 8 data bits LSB-first, optional parity, stop bit(s).
// Define UART_TX_TWO_STOP_EN to add the stop2 input selecting a two-bit-time stop.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    input  logic [1:0] parity_type,
`ifdef UART_TX_TWO_STOP_EN
    input  logic       stop2,
`endif
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done,
    output logic [2:0] state
);

    // Handshake: tx_start is a request that is accepted on the first edge where the
    // framer is idle; tx_busy is the "not ready" indication and stays high from that
    // edge until the edge that raises tx_done. Requests while busy are dropped.

    tx_state_e              state_q, state_n;
    logic [2:0]             bit_idx_q, bit_idx_n;
    logic [2:0]             bit_nxt;
    logic [DATA_BITS-1:0]   data_q;
    logic                   par_q;
    logic                   par_en_q;
    logic                   tx_n, busy_n, done_n;
    logic                   accept;
    logic                   baud_clear;
    logic                   bit_end;
`ifdef UART_TX_TWO_STOP_EN
    logic                   stop2_q;
    logic                   second_stop_q, second_stop_n;
`endif

    assign baud_clear = (state_q == ST_IDLE);
    assign state      = state_q;

    uart_baud_cnt #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_cnt (
        .clk     (clk),
        .reset   (reset),
        .clear   (baud_clear),
        .bit_end (bit_end)
    );

    always_comb begin
        state_n   = state_q;
        bit_idx_n = bit_idx_q;
        bit_nxt   = bit_idx_q + 3'd1;
        tx_n      = tx;
        busy_n    = tx_busy;
        done_n    = 1'b0;
        accept    = 1'b0;
`ifdef UART_TX_TWO_STOP_EN
        second_stop_n = second_stop_q;
`endif
        case (state_q)
            ST_IDLE: begin
                tx_n   = 1'b1;
                busy_n = 1'b0;
                if (tx_start) begin
                    accept    = 1'b1;
                    state_n   = ST_START;
                    bit_idx_n = 3'd0;
                    tx_n      = 1'b0;
                    busy_n    = 1'b1;
`ifdef UART_TX_TWO_STOP_EN
                    second_stop_n = 1'b0;
`endif
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_n   = ST_DATA;
                    bit_idx_n = 3'd0;
                    tx_n      = data_q[0];
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    if (bit_idx_q == 3'(DATA_BITS - 1)) begin
                        state_n = par_en_q ? ST_PARITY : ST_STOP;
                        tx_n    = par_en_q ? par_q : 1'b1;
                    end else begin
                        bit_idx_n = bit_nxt;
                        tx_n      = data_q[bit_nxt];
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    state_n = ST_STOP;
                    tx_n    = 1'b1;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
`ifdef UART_TX_TWO_STOP_EN
                    if (stop2_q && !second_stop_q) begin
                        second_stop_n = 1'b1;
                    end else begin
                        state_n = ST_IDLE;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                    end
`else
                    state_n = ST_IDLE;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
`endif
                    tx_n = 1'b1;
                end
            end
            default: begin
                state_n = ST_IDLE;
                tx_n    = 1'b1;
                busy_n  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            bit_idx_q <= 3'd0;
            tx        <= 1'b1;
            tx_busy   <= 1'b0;
            tx_done   <= 1'b0;
        end else begin
            state_q   <= state_n;
            bit_idx_q <= bit_idx_n;
            tx        <= tx_n;
            tx_busy   <= busy_n;
            tx_done   <= done_n;
        end
    end

    // Shadow copies of the request so the frame in flight ignores later input changes.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q   <= '0;
            par_q    <= 1'b0;
            par_en_q <= 1'b0;
        end else if (accept) begin
            data_q   <= tx_data;
            par_q    <= parity_bit(tx_data, parity_type);
            par_en_q <= parity_enabled(parity_type);
        end
    end

`ifdef UART_TX_TWO_STOP_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stop2_q       <= 1'b0;
            second_stop_q <= 1'b0;
        end else begin
            second_stop_q <= second_stop_n;
            if (accept) begin
                stop2_q <= stop2;
            end
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame with CLKS_PER_BIT=4: directed frames, expected serial bits
// and completion latency queued by the stimulus and checked by a negedge monitor.
module tb_uart_tx_frame;

    localparam int CPB = 4;

    logic       clk;
    logic       reset;
    logic       tx_start;
    logic [7:0] tx_data;
    logic [1:0] parity_type;
`ifdef UART_TX_TWO_STOP_EN
    logic       stop2;
`endif
    logic       tx;
    logic       tx_busy;
    logic       tx_done;
    logic [2:0] state;

    logic [0:0] exp_q[$];
    int         len_q[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    bit         in_frame = 0;

    uart_tx_frame #(
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .parity_type (parity_type),
`ifdef UART_TX_TWO_STOP_EN
        .stop2       (stop2),
`endif
        .tx          (tx),
        .tx_busy     (tx_busy),
        .tx_done     (tx_done),
        .state       (state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Bits are given in line order, first-sent bit in the MSB of the n-bit field.
    task automatic push_frame(input logic [11:0] bits, input int n, input int len);
        for (int i = n - 1; i >= 0; i--) exp_q.push_back(bits[i]);
        len_q.push_back(len);
    endtask

    // driver tasks
    task automatic send(input logic [7:0] d, input logic [1:0] pt, input logic s2);
        int guard = 0;
        @(posedge clk); #1;
        while (tx_busy && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        tx_data     = d;
        parity_type = pt;
`ifdef UART_TX_TWO_STOP_EN
        stop2       = s2;
`endif
        tx_start    = 1'b1;
        @(posedge clk); #1;
        tx_start    = 1'b0;
        tx_data     = ~d;
        parity_type = ~pt;
`ifdef UART_TX_TWO_STOP_EN
        stop2       = ~s2;
`endif
        check("accept_busy", tx_busy, 1'b1);
        check("accept_start_bit", tx, 1'b0);
    endtask

    task automatic wait_idle(input string name);
        int guard = 0;
        while ((tx_busy || len_q.size() != 0) && guard < 300) begin
            @(posedge clk); #1;
            guard++;
        end
        check(name, (guard < 300), 1'b1);
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        int off;
        if (reset) begin
            in_frame = 0;
            exp_q.delete();
            len_q.delete();
        end else begin
            if (in_frame) cyc++;
            else if (tx_busy) begin
                in_frame = 1;
                cyc = 0;
            end
            if (in_frame && tx_busy) begin
                off = cyc % CPB;
                if (off == 0 || off == CPB - 1) begin
                    if (exp_q.size() == 0) check("extra_bit", tx_busy, 1'b0);
                    else begin
                        check("serial_bit", tx, exp_q[0]);
                        if (off == CPB - 1) void'(exp_q.pop_front());
                    end
                end
            end
            if (tx_done) begin
                if (len_q.size() == 0) check("spurious_done", tx_done, 1'b0);
                else begin
                    check("done_cycle", cyc, len_q.pop_front());
                    check("done_idle_line", {tx, tx_busy}, 2'b10);
                end
                in_frame = 0;
            end
        end
    end

    // stimulus
    initial begin
        bit bad;
        int guard;
        reset       = 1'b1;
        tx_start    = 1'b0;
        tx_data     = 8'h00;
        parity_type = 2'b00;
`ifdef UART_TX_TWO_STOP_EN
        stop2       = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("reset_tx", tx, 1'b1);
        check("reset_busy", tx_busy, 1'b0);
        check("reset_done", tx_done, 1'b0);
        check("reset_state", state, 3'd0);
        reset = 1'b0;

        bad = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (tx !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) bad = 1;
        end
        check("idle_quiet", bad, 1'b0);

        // 8'hA5, no parity
        push_frame(12'b0101001011, 10, 40);
        send(8'hA5, 2'b00, 1'b0);
        wait_idle("frame_a5");

        // 8'h07 odd then even parity
        push_frame(12'b01110000001, 11, 44);
        send(8'h07, 2'b01, 1'b0);
        wait_idle("frame_07_odd");
        push_frame(12'b01110000011, 11, 44);
        send(8'h07, 2'b10, 1'b0);
        wait_idle("frame_07_even");

        // back-to-back 8'h55 then 8'hAA, with a stray request mid-frame
        push_frame(12'b0101010101, 10, 40);
        push_frame(12'b0010101011, 10, 40);
        send(8'h55, 2'b00, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        tx_start = 1'b1;
        tx_data  = 8'hFF;
        @(posedge clk); #1;
        tx_start = 1'b0;
        guard = 0;
        while (tx_done !== 1'b1 && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        check("b2b_done_seen", tx_done, 1'b1);
        tx_data     = 8'hAA;
        parity_type = 2'b00;
        tx_start    = 1'b1;
        @(posedge clk); #1;
        tx_start = 1'b0;
        check("b2b_start_bit", tx, 1'b0);
        check("b2b_busy", tx_busy, 1'b1);
        wait_idle("frame_b2b");

        // reset during data bit 3 abandons the frame
        push_frame(12'b0011010011, 10, 40);
        send(8'h96, 2'b00, 1'b0);
        repeat (17) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check("abort_tx", tx, 1'b1);
        check("abort_state", state, 3'd0);
        check("abort_busy", tx_busy, 1'b0);
        reset = 1'b0;
        bad = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (tx_done !== 1'b0 || tx !== 1'b1) bad = 1;
        end
        check("abort_no_done", bad, 1'b0);

        // 8'h3C even parity after the abort
        push_frame(12'b00011110001, 11, 44);
        send(8'h3C, 2'b10, 1'b0);
        wait_idle("frame_3c");

`ifdef UART_TX_TWO_STOP_EN
        push_frame(12'b01111111111, 11, 44);
        send(8'hFF, 2'b00, 1'b1);
        wait_idle("frame_ff_two_stop");
`endif

        repeat (3) @(posedge clk);
        #1;
        check("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
